dest_to_user_mapper: RTL and testbench
======================================

DEST_TO_USER_MAPPER -- requirements
Module: dest_to_user_mapper

Interface
REQ-001 Parameter DATA_WIDTH, default 8: tdata width in bits.
REQ-002 Parameter DEST_WIDTH, default 2: s_axis_tdest width in bits; map table depth is 2**DEST_WIDTH.
REQ-003 Parameter USER_WIDTH, default 2: m_axis_tuser and map entry width in bits.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Ports s_axis_tdata/tvalid/tready/tlast/tdest: AXI4-Stream slave, widths DATA_WIDTH/1/1/1/DEST_WIDTH; tready is an output.
REQ-007 Ports m_axis_tdata/tvalid/tready/tlast/tuser: AXI4-Stream master, widths DATA_WIDTH/1/1/1/USER_WIDTH; tready is an input.
REQ-008 Ports cfg_we (in, 1), cfg_addr (in, DEST_WIDTH), cfg_data (in, USER_WIDTH): write port for the map table.
REQ-009 Port dest_err (out, 1): sticky flag, set when tdest changes mid-frame.
REQ-010 Port dest_err_clr (in, 1): clears dest_err.
REQ-011 Port frame_cnt (out, 32): count of frames completed at the master side.

Function
REQ-012 The map table SHALL be 2**DEST_WIDTH entries of USER_WIDTH bits; while cfg_we=1, entry cfg_addr takes cfg_data at the clock edge.
REQ-013 At reset, entry i SHALL be i modulo 2**USER_WIDTH (identity, truncated or zero-extended).
REQ-014 The block SHALL track a frame state: IDLE (next beat is first of frame) and IN_FRAME; an accepted beat with tlast=0 moves the state to IN_FRAME, and one with tlast=1 moves it to IDLE.
REQ-015 On the first accepted beat of a frame, the block SHALL latch table[s_axis_tdest] and s_axis_tdest into frame registers; that beat carries the looked-up value, using table contents before any same-cycle cfg write.
REQ-016 Every beat of a frame SHALL carry the tuser latched at its first beat; table writes and tdest changes mid-frame SHALL NOT alter tuser for the remainder of that frame.
REQ-017 A beat accepted in IN_FRAME whose tdest differs from the latched tdest SHALL set dest_err the next cycle; the beat itself is forwarded unchanged.
REQ-018 dest_err_clr=1 SHALL clear dest_err; a simultaneous set SHALL take priority (dest_err stays 1).
REQ-019 The datapath SHALL be a registered output stage plus a one-entry skid buffer: latency from s-side acceptance to m_axis_tvalid is exactly 1 cycle when the output is empty or draining; sustained throughput is 1 beat/cycle with m_axis_tready held high.
REQ-020 s_axis_tready SHALL be registered and equal NOT(skid buffer full); it SHALL NOT combinationally depend on m_axis_tready.
REQ-021 Once asserted, m_axis_tvalid SHALL stay high, and tdata/tlast/tuser SHALL stay stable, until m_axis_tready=1; beat order is preserved and no beat is dropped or duplicated.
REQ-022 When the output register holds a beat and m_axis_tready=0, an accepted input beat SHALL go to the skid buffer; s_axis_tready drops the next cycle. When the output drains, the skid entry moves to the output and s_axis_tready rises the next cycle.
REQ-023 frame_cnt SHALL increment by 1 for each master-side transfer with tlast=1 (tvalid and tready both 1), and SHALL wrap from 2**32-1 to 0.

Reset
REQ-024 While rst=1: m_axis_tvalid=0, s_axis_tready=0, skid empty, frame state IDLE, dest_err=0, frame_cnt=0, table at identity per REQ-013.
REQ-025 In the first cycle after rst deasserts, s_axis_tready SHALL be 1.
REQ-026 Reset asserted mid-frame SHALL discard all buffered beats; the next accepted beat is treated as a first beat.
REQ-027 m_axis_tdata/tlast/tuser are don't-care while m_axis_tvalid=0.

Verification
REQ-028 Defaults, no cfg writes: 3-beat frame with tdest=2, m_axis_tready=1 -> three output beats with tuser=2, the first one cycle after input; frame_cnt=1.
REQ-029 cfg_we with addr=1, data=3, then a frame with tdest=1 -> tuser=3 on all beats; writing entry 1 to 0 during the frame -> remaining beats still tuser=3, next frame tuser=0.
REQ-030 4-beat frame with tdest=0 on beat 1 and tdest=3 on beat 3 -> all beats tuser=0, dest_err=1 after beat 3; dest_err_clr pulse -> dest_err=0.
REQ-031 Continuous input, m_axis_tready low for 3 cycles -> s_axis_tready low from the 2nd stalled cycle, no beat lost or reordered, full rate resumes after release.
REQ-032 rst pulse after beat 2 of a 5-beat frame -> m_axis_tvalid=0, frame_cnt=0; a new frame with tdest=1 -> tuser=table[1].
REQ-033 frame_cnt forced near wrap (DATA_WIDTH=32, DEST_WIDTH=3, USER_WIDTH=1): 2**32-1 -> 0 on the next frame end; dest 5 maps to tuser 1 at reset.

Source files
------------

// File: rtl/dest_to_user_mapper.sv
// Maps AXI4-Stream tdest to tuser through a writable table, latched per frame; 1-cycle latency.
// Registered output plus one-entry skid buffer; s_axis_tready is registered and drops only when the skid fills.
module dest_to_user_mapper #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 2,
  parameter int USER_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  cfg_we,
  input  logic [DEST_WIDTH-1:0] cfg_addr,
  input  logic [USER_WIDTH-1:0] cfg_data,
  output logic                  dest_err,
  input  logic                  dest_err_clr,
  output logic [31:0]           frame_cnt
);

  localparam int DEPTH = 2**DEST_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [USER_WIDTH-1:0] r_map [DEPTH];
  logic [USER_WIDTH-1:0] r_frame_user;
  logic [DEST_WIDTH-1:0] r_frame_dest;
  logic                  r_dest_err;
  logic [31:0]           r_frame_cnt;
  beat_t                 r_out;
  logic                  r_out_vld;
  beat_t                 r_skid;
  logic                  r_skid_vld;
  logic                  r_s_rdy;

  logic                  w_s_acc;
  logic                  w_first;
  logic                  w_dest_mis;
  logic                  w_out_take;
  beat_t                 w_beat;

  assign w_s_acc    = s_axis_tvalid && r_s_rdy;
  assign w_first    = (r_state == ST_IDLE);
  assign w_dest_mis = w_s_acc && !w_first && (s_axis_tdest != r_frame_dest);
  assign w_out_take = !r_out_vld || m_axis_tready;

  // The first beat reads the table directly, so a same-cycle cfg write is not seen.
  always_comb begin
    w_beat      = '0;
    w_beat.dat  = s_axis_tdata;
    w_beat.last = s_axis_tlast;
    w_beat.user = w_first ? r_map[s_axis_tdest] : r_frame_user;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_s_acc) w_state_nxt = s_axis_tlast ? ST_IDLE : ST_IN_FRAME;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_map[i] <= USER_WIDTH'(i);
    end else if (cfg_we) begin
      r_map[cfg_addr] <= cfg_data;
    end
  end

  // A mismatch in the same cycle as a clear wins, so no error is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_user <= '0;
      r_frame_dest <= '0;
      r_dest_err   <= 1'b0;
    end else begin
      if (w_s_acc && w_first) begin
        r_frame_user <= r_map[s_axis_tdest];
        r_frame_dest <= s_axis_tdest;
      end
      if (w_dest_mis)        r_dest_err <= 1'b1;
      else if (dest_err_clr) r_dest_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_s_rdy    <= 1'b0;
    end else if (w_out_take) begin
      r_s_rdy <= 1'b1;
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_s_acc;
        if (w_s_acc) r_out <= w_beat;
      end
    end else if (w_s_acc) begin
      // Output is stalled: park the beat and close the input next cycle.
      r_skid     <= w_beat;
      r_skid_vld <= 1'b1;
      r_s_rdy    <= 1'b0;
    end else begin
      r_s_rdy <= !r_skid_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                                r_frame_cnt <= '0;
    else if (r_out_vld && m_axis_tready && r_out.last)      r_frame_cnt <= r_frame_cnt + 32'd1;
  end

  assign s_axis_tready = r_s_rdy;
  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tdata  = r_out.dat;
  assign m_axis_tlast  = r_out.last;
  assign m_axis_tuser  = r_out.user;
  assign dest_err      = r_dest_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_dest_to_user_mapper.sv
// Scoreboard bench for dest_to_user_mapper: default instance plus a wide instance for counter wrap.
module tb_dest_to_user_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tready, s_tlast;
  logic [1:0] s_tdest;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic [1:0] m_tuser;
  logic       cfg_we;
  logic [1:0] cfg_addr, cfg_data;
  logic       dest_err, dest_err_clr;
  logic [31:0] frame_cnt;

  logic [31:0] u2_s_tdata, u2_m_tdata, u2_frame_cnt;
  logic        u2_s_tvalid, u2_s_tready, u2_s_tlast, u2_m_tvalid, u2_m_tready, u2_m_tlast;
  logic [2:0]  u2_s_tdest, u2_cfg_addr;
  logic [0:0]  u2_m_tuser, u2_cfg_data;
  logic        u2_cfg_we, u2_dest_err, u2_dest_err_clr;

  dest_to_user_mapper u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dest_err(dest_err), .dest_err_clr(dest_err_clr), .frame_cnt(frame_cnt)
  );

  dest_to_user_mapper #(.DATA_WIDTH(32), .DEST_WIDTH(3), .USER_WIDTH(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(u2_s_tdata), .s_axis_tvalid(u2_s_tvalid), .s_axis_tready(u2_s_tready),
    .s_axis_tlast(u2_s_tlast), .s_axis_tdest(u2_s_tdest),
    .m_axis_tdata(u2_m_tdata), .m_axis_tvalid(u2_m_tvalid), .m_axis_tready(u2_m_tready),
    .m_axis_tlast(u2_m_tlast), .m_axis_tuser(u2_m_tuser),
    .cfg_we(u2_cfg_we), .cfg_addr(u2_cfg_addr), .cfg_data(u2_cfg_data),
    .dest_err(u2_dest_err), .dest_err_clr(u2_dest_err_clr), .frame_cnt(u2_frame_cnt)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
    logic [1:0] user;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] tb_map [4];
  logic       tb_first;
  logic [1:0] tb_user;
  int         tb_frames;

  // Output monitor: every master-side transfer is matched against the next expected beat.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h last=%b user=%h, expected no beat", m_tdata, m_tlast, m_tuser);
      end else begin
        mon_e = sb_q.pop_front();
        if ({m_tdata, m_tlast, m_tuser} !== mon_e) begin
          errors++;
          $display("FAIL sb_beat: got data=%h last=%b user=%h, expected data=%h last=%b user=%h",
                   m_tdata, m_tlast, m_tuser, mon_e.dat, mon_e.last, mon_e.user);
        end
        if (m_tlast) tb_frames++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) tb_map[i] = 2'(i);
    tb_first  = 1'b1;
    tb_user   = 2'd0;
    tb_frames = 0;
    sb_q.delete();
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, input logic [1:0] dst);
    int n;
    n = 0;
    s_tdata = d; s_tlast = l; s_tdest = dst; s_tvalid = 1'b1;
    while (s_tready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL drive_timeout: s_axis_tready=%b after %0d cycles, expected 1", s_tready, n);
      s_tvalid = 1'b0;
      return;
    end
    if (tb_first) tb_user = tb_map[dst];
    sb_q.push_back({d, l, tb_user});
    tb_first = l;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tb_map[a] = d;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, s_tready, dest_err} !== 3'b000 || frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got tvalid=%b tready=%b dest_err=%b frame_cnt=%0d, expected 0 0 0 0",
               m_tvalid, s_tready, dest_err, frame_cnt);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready: got %b, expected 1", s_tready);
    end
  endtask

  task automatic test_default_map();
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL default_idle_tvalid: got %b, expected 0", m_tvalid);
    end
    drive_beat(8'h11, 1'b0, 2'd2);
    checks++;
    if (m_tvalid !== 1'b1 || m_tuser !== 2'd2) begin
      errors++;
      $display("FAIL default_latency: got tvalid=%b tuser=%h one cycle after input, expected 1 and 2", m_tvalid, m_tuser);
    end
    drive_beat(8'h12, 1'b0, 2'd2);
    drive_beat(8'h13, 1'b1, 2'd2);
    wait_drain("default");
    checks++;
    if (frame_cnt !== 32'd1 || tb_frames != 1) begin
      errors++;
      $display("FAIL default_frame_cnt: got %0d (model %0d), expected 1", frame_cnt, tb_frames);
    end
  endtask

  task automatic test_cfg_map();
    cfg_write(2'd1, 2'd3);
    drive_beat(8'h21, 1'b0, 2'd1);
    drive_beat(8'h22, 1'b0, 2'd1);
    cfg_write(2'd1, 2'd0);
    drive_beat(8'h23, 1'b0, 2'd1);
    checks++;
    if (m_tuser !== 2'd3) begin
      errors++;
      $display("FAIL cfg_midframe_user: got %h, expected 3", m_tuser);
    end
    drive_beat(8'h24, 1'b1, 2'd1);
    drive_beat(8'h25, 1'b1, 2'd1);
    checks++;
    if (m_tuser !== 2'd0) begin
      errors++;
      $display("FAIL cfg_next_frame_user: got %h, expected 0", m_tuser);
    end
    wait_drain("cfg");
  endtask

  task automatic test_dest_err();
    drive_beat(8'h31, 1'b0, 2'd0);
    drive_beat(8'h32, 1'b0, 2'd0);
    checks++;
    if (dest_err !== 1'b0) begin
      errors++;
      $display("FAIL dest_err_early: got %b, expected 0", dest_err);
    end
    drive_beat(8'h33, 1'b0, 2'd3);
    checks++;
    if (dest_err !== 1'b1) begin
      errors++;
      $display("FAIL dest_err_set: got %b, expected 1", dest_err);
    end
    drive_beat(8'h34, 1'b1, 2'd0);
    wait_drain("dest_err");
    checks++;
    if (dest_err !== 1'b1) begin
      errors++;
      $display("FAIL dest_err_sticky: got %b, expected 1", dest_err);
    end
    dest_err_clr = 1'b1;
    @(posedge clk); #1;
    dest_err_clr = 1'b0;
    checks++;
    if (dest_err !== 1'b0) begin
      errors++;
      $display("FAIL dest_err_clear: got %b, expected 0", dest_err);
    end
    drive_beat(8'h35, 1'b0, 2'd1);
    dest_err_clr = 1'b1;
    drive_beat(8'h36, 1'b1, 2'd2);
    dest_err_clr = 1'b0;
    checks++;
    if (dest_err !== 1'b1) begin
      errors++;
      $display("FAIL dest_err_set_priority: got %b, expected 1", dest_err);
    end
    wait_drain("dest_err_prio");
    dest_err_clr = 1'b1;
    @(posedge clk); #1;
    dest_err_clr = 1'b0;
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] hold;
    m_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) drive_beat(8'h40 + 8'(i), (i == 11), 2'(i % 4 == 0 ? 0 : 0));
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        m_tready = 1'b0;
        hold = m_tdata;
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL stall_c0: got tready=%b tvalid=%b, expected 1 1", s_tready, m_tvalid);
        end
        for (int c = 1; c < 3; c++) begin
          @(posedge clk); #1;
          checks++;
          if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== hold) begin
            errors++;
            $display("FAIL stall_c%0d: got tready=%b tvalid=%b data=%h, expected 0 1 %h",
                     c, s_tready, m_tvalid, m_tdata, hold);
          end
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        checks++;
        if (s_tready !== 1'b0) begin
          errors++;
          $display("FAIL stall_release_c3: got tready=%b, expected 0", s_tready);
        end
        for (int c = 4; c < 7; c++) begin
          @(posedge clk); #1;
          checks++;
          if (s_tready !== 1'b1 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume_c%0d: got tready=%b tvalid=%b, expected 1 1", c, s_tready, m_tvalid);
          end
        end
      end
    join
    wait_drain("stall");
  endtask

  task automatic test_reset_mid_frame();
    drive_beat(8'h51, 1'b0, 2'd3);
    drive_beat(8'h52, 1'b0, 2'd3);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got tvalid=%b frame_cnt=%0d, expected 0 0", m_tvalid, frame_cnt);
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    drive_beat(8'h61, 1'b1, 2'd1);
    checks++;
    if (m_tuser !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_new_frame_user: got %h, expected 1", m_tuser);
    end
    wait_drain("reset_mid");
    checks++;
    if (frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL reset_mid_frame_cnt: got %0d, expected 1", frame_cnt);
    end
  endtask

  task automatic test_wrap();
    u2_m_tready = 1'b1;
    force u_dut2.r_frame_cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release u_dut2.r_frame_cnt;
    @(posedge clk); #1;
    checks++;
    if (u2_frame_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h, expected ffffffff", u2_frame_cnt);
    end
    u2_s_tdata = 32'hCAFE_F00D; u2_s_tlast = 1'b1; u2_s_tdest = 3'd5; u2_s_tvalid = 1'b1;
    checks++;
    if (u2_s_tready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_tready: got %b, expected 1", u2_s_tready);
    end
    @(posedge clk); #1;
    u2_s_tvalid = 1'b0;
    checks++;
    if (u2_m_tvalid !== 1'b1 || u2_m_tuser !== 1'b1 || u2_m_tdata !== 32'hCAFE_F00D || u2_m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL wrap_dest5_beat: got tvalid=%b tuser=%b data=%h last=%b, expected 1 1 cafef00d 1",
               u2_m_tvalid, u2_m_tuser, u2_m_tdata, u2_m_tlast);
    end
    @(posedge clk); #1;
    checks++;
    if (u2_frame_cnt !== 32'd0 || u2_dest_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_frame_cnt: got cnt=%h dest_err=%b, expected 0 0", u2_frame_cnt, u2_dest_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdest = '0;
    m_tready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; dest_err_clr = 1'b0;
    u2_s_tdata = '0; u2_s_tvalid = 1'b0; u2_s_tlast = 1'b0; u2_s_tdest = '0;
    u2_m_tready = 1'b1; u2_cfg_we = 1'b0; u2_cfg_addr = '0; u2_cfg_data = '0; u2_dest_err_clr = 1'b0;
    model_reset();
    @(posedge clk); #1;

    test_reset();
    test_default_map();
    test_cfg_map();
    test_dest_err();
    test_back_to_back_stall();
    test_reset_mid_frame();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
